seq_shifter: RTL
================

Name: seq_shifter

Overview:
Multi-cycle, parametrised successor to the datapath shifter. It shifts or rotates a WIDTH-bit operand by a run-time amount, applying up to STEP bit positions per clock. A start/done handshake lets the FSM controller issue variable-distance shift and rotate instructions. It also reports the last bit shifted out (carry) and a zero flag for the status register.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
STEP, 1, maximum bit positions shifted per SHIFT cycle (1..WIDTH)
AMT_W, $clog2(WIDTH)+1, width of shift-amount port (represents 0..2*WIDTH-1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
shift_op  input  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 110/111 illegal
shift_amt  input  AMT_W  requested distance
shift_in  input  WIDTH  operand
shift_out  output  WIDTH  result; valid when done=1, held until next accepted start
carry_out  output  1  last bit shifted or rotated out
zero  output  1  shift_out == 0
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse, result ready
op_err  output  1  high with done when shift_op was illegal

Behaviour:
- One clock, reset is synchronous and active-low: on a clk edge with rst_n=0 -> state IDLE, shift_out=0, carry_out=0, zero=1, busy=0, done=0, op_err=0, internal counter=0. Reset overrides start and aborts an in-flight SHIFT with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE with start=1: latch shift_in, shift_op, and effective amount N into internal registers; clear carry.
  - N = min(shift_amt, WIDTH) for LSL/LSR/ASR; N = shift_amt mod WIDTH for ROL/ROR; N = 0 for pass and illegal ops.
  - N>0 -> SHIFT; N=0 -> DONE.
- DONE with start=0 -> IDLE. A start in DONE is accepted, so back-to-back operations are allowed.
- SHIFT: each cycle applies k = min(STEP, remaining) positions and decrements remaining by k. When remaining reaches 0 -> DONE.
  - LSL: fill 0 at LSB.
  - LSR: fill 0 at MSB.
  - ASR: replicate the latched MSB.
  - ROL/ROR: wrap around.
- carry_out after each SHIFT cycle = the last bit that left the word in that cycle. For rotates this is the bit that wrapped: new LSB for ROL, new MSB for ROR.
- start is ignored while busy=1. Operand inputs are ignored outside the accepting cycle.
- Latency: done is high exactly ceil(N/STEP)+1 cycles after the start edge (N=0 -> 1 cycle).
- done=1 only in DONE. shift_out, carry_out and zero stay stable from DONE until the next accepted start. During SHIFT they hold intermediate values that are not guaranteed.
- Pass or illegal op: shift_out=shift_in, carry_out=0. op_err=1 for the DONE cycle only when the op is illegal.
- Results are bit-exact with SystemVerilog << (LSL), >> (LSR), >>> on a signed operand (ASR) by N, and with the corresponding rotate.

Test Plan:
- WIDTH=16, STEP=1, LSL, amt=1, in=0xF0CF -> done 2 cycles after start; out=0xE19E, carry=1, zero=0.
- ASR, amt=4, in=0xF0CF, STEP=1 -> done after 5 cycles; out=0xFF0C, carry=1. Rerun with STEP=4 -> done after 2 cycles, same out and carry.
- LSR, amt=17, in=0xF0CF -> clamped to 16; done after 17 cycles; out=0x0000, carry=1, zero=1. ROR, amt=20 -> out=0xFF0C, carry=1, done after 5 cycles.
- pass, amt=9, in=0xF0CF -> done next cycle, out=0xF0CF, carry=0. op=3'b110 -> same result with op_err=1.
- LSL, amt=8 started; start pulsed with new operands at cycle 3 -> ignored; result 0xCF00, carry=0. Then start asserted in the DONE cycle -> accepted, no IDLE cycle in between.
- LSL, amt=8; rst_n=0 at cycle 4 -> next edge: IDLE, busy=0, out=0, zero=1, no done pulse. A new start after reset completes normally.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: applies up to STEP bit positions per clock under a
// start/done handshake, reporting the last bit shifted out and a zero flag.
module seq_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       shift_op,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [WIDTH-1:0] shift_in,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             op_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_rem;
  logic             r_err;

  logic [AMT_W-1:0] w_n;
  logic [AMT_W-1:0] w_k;
  logic [WIDTH-1:0] w_data;
  logic             w_carry;

  // Effective distance: shifts saturate at WIDTH, rotates wrap modulo WIDTH.
  always_comb begin
    w_n = '0;
    case (shift_op)
      OP_LSL, OP_LSR, OP_ASR: w_n = (shift_amt > WIDTH_A) ? WIDTH_A : shift_amt;
      OP_ROL, OP_ROR:         w_n = shift_amt % WIDTH_A;
      default:                w_n = '0;
    endcase
  end

  assign w_k = (r_rem > STEP_A) ? STEP_A : r_rem;

  // Unrolled single-bit steps; only the first w_k of them take effect.
  always_comb begin
    w_data  = r_data;
    w_carry = r_carry;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < w_k) begin
        case (r_op)
          OP_LSL: begin
            w_carry = w_data[WIDTH-1];
            w_data  = {w_data[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            w_carry = w_data[0];
            w_data  = {1'b0, w_data[WIDTH-1:1]};
          end
          OP_ASR: begin
            w_carry = w_data[0];
            w_data  = {w_data[WIDTH-1], w_data[WIDTH-1:1]};
          end
          OP_ROL: begin
            w_data  = {w_data[WIDTH-2:0], w_data[WIDTH-1]};
            w_carry = w_data[0];
          end
          OP_ROR: begin
            w_data  = {w_data[0], w_data[WIDTH-1:1]};
            w_carry = w_data[WIDTH-1];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_op    <= 3'b000;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_data  <= shift_in;
            r_carry <= 1'b0;
            r_op    <= shift_op;
            r_rem   <= w_n;
            r_err   <= shift_op[2] & shift_op[1];
            r_state <= (w_n == '0) ? S_DONE : S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_data  <= w_data;
          r_carry <= w_carry;
          r_rem   <= r_rem - w_k;
          if (r_rem == w_k) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign shift_out = r_data;
  assign carry_out = r_carry;
  assign zero      = (r_data == '0);
  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign op_err    = done & r_err;

endmodule
